// File: rtl/riscv_m_pkg.sv
// riscv_m_pkg: shared RV32M constants, state encoding and operand-sign helpers
package riscv_m_pkg;
    localparam int XLEN = 32;
    localparam int ITER = XLEN;
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
    function automatic logic a_signed(input logic [2:0] f);
        return f == F3_MULH || f == F3_MULHSU || f == F3_DIV || f == F3_REM;
    endfunction
    function automatic logic b_signed(input logic [2:0] f);
        return f == F3_MULH || f == F3_DIV || f == F3_REM;
    endfunction
endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: issue and write-back signals between the core and the multiply/divide unit
interface muldiv_unit_if;
    import riscv_m_pkg::*;
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [4:0]      rd_in;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;
    logic            we;
    modport master (output start, funct3, op_a, op_b, rd_in, input busy, done, result, rd_out, we);
    modport slave  (input start, funct3, op_a, op_b, rd_in, output busy, done, result, rd_out, we);
endinterface

// File: rtl/muldiv_unit_div_iter.sv
// div_iter: one restoring-divide step producing the next partial remainder and a quotient bit
module div_iter
    import riscv_m_pkg::*;
(
    input  logic [XLEN-1:0] i_rem,
    input  logic            i_bit,
    input  logic [XLEN-1:0] i_div,
    output logic [XLEN-1:0] o_rem,
    output logic            o_q
);
    logic [XLEN-1:0] w_low;
    assign w_low = {i_rem[XLEN-2:0], i_bit};
    // the shifted remainder's carry-out bit alone guarantees it exceeds the divisor
    assign o_q   = i_rem[XLEN-1] | (w_low >= i_div);
    assign o_rem = o_q ? w_low - i_div : w_low;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, fixed 32-cycle latency from accept to done
module muldiv_unit
    import riscv_m_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    muldiv_unit_if.slave  bus
);
    state_t          r_state, w_state_n;
    logic [4:0]      r_cnt, r_rd;
    logic [2:0]      r_f3;
    logic [XLEN-1:0] r_hi, r_lo, r_opnd, r_op_a, r_result;
    logic            r_neg_q, r_neg_r, r_dz, r_ovf;
    logic            w_a_neg, w_b_neg, w_q, w_accept;
    logic [XLEN-1:0] w_a_mag, w_b_mag, w_rem_n, w_hi_n, w_lo_n, w_quo, w_rem, w_res;
    logic [XLEN:0]   w_sum;
    logic [2*XLEN-1:0] w_prod;

    assign w_accept = r_state == IDLE && bus.start;
    assign w_a_neg  = a_signed(bus.funct3) & bus.op_a[XLEN-1];
    assign w_b_neg  = b_signed(bus.funct3) & bus.op_b[XLEN-1];
    assign w_a_mag  = w_a_neg ? -bus.op_a : bus.op_a;
    assign w_b_mag  = w_b_neg ? -bus.op_b : bus.op_b;

    // multiply: {r_hi, r_lo} is the product register, multiplier shifts out of r_lo
    assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);

    div_iter u_div (
        .i_rem (r_hi),
        .i_bit (r_lo[XLEN-1]),
        .i_div (r_opnd),
        .o_rem (w_rem_n),
        .o_q   (w_q)
    );

    assign w_hi_n = r_f3[2] ? w_rem_n : w_sum[XLEN:1];
    assign w_lo_n = r_f3[2] ? {r_lo[XLEN-2:0], w_q} : {w_sum[0], r_lo[XLEN-1:1]};
    assign w_prod = r_neg_q ? -{w_hi_n, w_lo_n} : {w_hi_n, w_lo_n};
    assign w_quo  = r_dz ? '1 : r_ovf ? {1'b1, {(XLEN-1){1'b0}}} : r_neg_q ? -w_lo_n : w_lo_n;
    assign w_rem  = r_dz ? r_op_a : r_ovf ? '0 : r_neg_r ? -w_hi_n : w_hi_n;
    assign w_res  = !r_f3[2] ? (r_f3[1:0] == 2'b00 ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN])
                             : (r_f3[1] ? w_rem : w_quo);

    always_comb begin
        w_state_n = IDLE;
        w_state_n = r_state == IDLE ? (bus.start ? CALC : IDLE) :
                    r_state == CALC ? (r_cnt == '0 ? DONE : CALC) : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_rd     <= '0;
            r_f3     <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opnd   <= '0;
            r_op_a   <= '0;
            r_result <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_state <= w_state_n;
            if (w_accept) begin
                r_f3    <= bus.funct3;
                r_cnt   <= 5'(ITER-1);
                r_rd    <= bus.rd_in;
                r_op_a  <= bus.op_a;
                r_hi    <= '0;
                r_lo    <= bus.funct3[2] ? w_a_mag : w_b_mag;
                r_opnd  <= bus.funct3[2] ? w_b_mag : w_a_mag;
                r_neg_q <= w_a_neg ^ w_b_neg;
                r_neg_r <= w_a_neg;
                r_dz    <= bus.op_b == '0;
                r_ovf   <= bus.funct3[2] && b_signed(bus.funct3) &&
                           bus.op_a == {1'b1, {(XLEN-1){1'b0}}} && bus.op_b == '1;
            end else if (r_state == CALC) begin
                r_hi  <= w_hi_n;
                r_lo  <= w_lo_n;
                r_cnt <= r_cnt - 5'd1;
                if (r_cnt == '0)
                    r_result <= w_res;
            end
        end
    end

    assign bus.busy   = r_state != IDLE;
    assign bus.done   = r_state == DONE;
    assign bus.result = r_result;
    assign bus.rd_out = r_rd;
    assign bus.we     = bus.done && r_rd != '0;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit against an arithmetic model
module tb_muldiv_unit;
    import riscv_m_pkg::*;
    logic clk = 1'b0;
    logic rst;
    int   n_pass = 0;
    int   n_total = 0;
    muldiv_unit_if bus();
    muldiv_unit dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic signed [63:0] sa, sb, ub;
        logic ovf;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ub = {32'b0, b};
        ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
        case (f)
            F3_MUL:    begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            F3_MULH:   begin p = sa * sb; return p[63:32]; end
            F3_MULHSU: begin p = sa * ub; return p[63:32]; end
            F3_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            F3_DIV:    return b == 0 ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            F3_REM:    return b == 0 ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            F3_DIVU:   return b == 0 ? 32'hFFFF_FFFF : a / b;
            default:   return b == 0 ? a : a % b;
        endcase
    endfunction

    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                         output int lat, output logic busy_ok, output logic [31:0] res,
                         output logic [4:0] rdo, output logic weo);
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = f; bus.op_a = a; bus.op_b = b; bus.rd_in = rd;
        @(posedge clk);
        lat = -1; busy_ok = 1'b1; res = '0; rdo = '0; weo = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 0) begin
                bus.start = 1'b0; bus.op_a = $urandom; bus.op_b = $urandom;
                bus.funct3 = 3'($urandom); bus.rd_in = 5'($urandom);
            end
            busy_ok &= bus.busy;
            if (bus.done) begin
                lat = k; res = bus.result; rdo = bus.rd_out; weo = bus.we;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.start = 1'b0; bus.funct3 = '0; bus.op_a = '0; bus.op_b = '0; bus.rd_in = '0;
        repeat (2) @(negedge clk);
        n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
        n_total++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done); else n_pass++;
        n_total++; if (bus.we !== 1'b0) $display("FAIL reset_we: got %b want 0", bus.we); else n_pass++;
        n_total++; if (bus.result !== 32'h0) $display("FAIL reset_result: got %h want 0", bus.result); else n_pass++;
        n_total++; if (bus.rd_out !== 5'h0) $display("FAIL reset_rd_out: got %h want 0", bus.rd_out); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_directed;
        logic [2:0]  vf[11] = '{F3_MUL, F3_MULH, F3_MULHU, F3_MULHSU, F3_DIV, F3_REM, F3_DIVU, F3_DIV, F3_REM, F3_DIVU, F3_REMU};
        logic [31:0] va[11] = '{7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9,
                                32'h80000000, 32'h80000000, 123, 123};
        logic [31:0] vb[11] = '{6, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, 2, 2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0};
        logic [31:0] ve[11] = '{42, 32'h0, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFC,
                                32'h80000000, 32'h0, 32'hFFFFFFFF, 123};
        logic [4:0]  vr[11] = '{5, 1, 2, 3, 4, 6, 7, 8, 9, 10, 31};
        int lat; logic bok; logic [31:0] res; logic [4:0] rdo; logic weo;
        for (int i = 0; i < 11; i++) begin
            do_op(vf[i], va[i], vb[i], vr[i], lat, bok, res, rdo, weo);
            n_total++; if (res !== ve[i]) $display("FAIL dir%0d_result: got %h want %h", i, res, ve[i]); else n_pass++;
            n_total++; if (lat !== 32) $display("FAIL dir%0d_latency: got %0d want 32", i, lat); else n_pass++;
            n_total++; if (bok !== 1'b1) $display("FAIL dir%0d_busy: got %b want 1", i, bok); else n_pass++;
            n_total++; if (rdo !== vr[i]) $display("FAIL dir%0d_rd_out: got %0d want %0d", i, rdo, vr[i]); else n_pass++;
            n_total++; if (weo !== 1'b1) $display("FAIL dir%0d_we: got %b want 1", i, weo); else n_pass++;
        end
    endtask

    task automatic test_random;
        int lat; logic bok; logic [31:0] res, a, b, e; logic [4:0] rdo, rd; logic weo; logic [2:0] f;
        for (int i = 0; i < 30; i++) begin
            f = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom; rd = 5'($urandom);
            if (i % 6 == 0) b = 0;
            if (i % 5 == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            if (i % 4 == 2) b = 32'($urandom_range(1, 255));
            e = model(f, a, b);
            do_op(f, a, b, rd, lat, bok, res, rdo, weo);
            n_total++; if (res !== e) $display("FAIL rnd%0d_result f=%0d a=%h b=%h: got %h want %h", i, f, a, b, res, e); else n_pass++;
            n_total++; if (lat !== 32) $display("FAIL rnd%0d_latency: got %0d want 32", i, lat); else n_pass++;
            n_total++; if (weo !== (rd != 0)) $display("FAIL rnd%0d_we: got %b want %b", i, weo, rd != 0); else n_pass++;
            n_total++; if (rdo !== rd) $display("FAIL rnd%0d_rd_out: got %0d want %0d", i, rdo, rd); else n_pass++;
        end
    endtask

    task automatic test_rd_zero;
        int lat; logic bok; logic [31:0] res; logic [4:0] rdo; logic weo;
        do_op(F3_MUL, 5, 5, 0, lat, bok, res, rdo, weo);
        n_total++; if (lat !== 32) $display("FAIL rd0_done: got latency %0d want 32", lat); else n_pass++;
        n_total++; if (weo !== 1'b0) $display("FAIL rd0_we: got %b want 0", weo); else n_pass++;
        n_total++; if (res !== 32'd25) $display("FAIL rd0_result: got %h want 19", res); else n_pass++;
    endtask

    task automatic test_handshake;
        int n_done = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = F3_MUL; bus.op_a = 9; bus.op_b = 11; bus.rd_in = 12;
        @(posedge clk);
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (bus.done) begin
                n_done++;
                if (n_done == 1) begin
                    n_total++; if (k !== 32) $display("FAIL hs_latency: got %0d want 32", k); else n_pass++;
                    n_total++; if (bus.result !== 32'd99) $display("FAIL hs_result: got %h want 63", bus.result); else n_pass++;
                    n_total++; if (bus.rd_out !== 5'd12) $display("FAIL hs_rd_out: got %0d want 12", bus.rd_out); else n_pass++;
                end
            end
            if (k == 0) bus.start = 1'b0;
            if (k == 5) begin
                n_total++; if (bus.busy !== 1'b1) $display("FAIL hs_busy5: got %b want 1", bus.busy); else n_pass++;
                bus.start = 1'b1; bus.funct3 = F3_DIV; bus.op_a = 100; bus.op_b = 3; bus.rd_in = 20;
            end
            if (k == 6) bus.start = 1'b0;
            if (k == 32) begin bus.start = 1'b1; bus.funct3 = F3_REMU; bus.op_a = 50; bus.op_b = 7; bus.rd_in = 21; end
            if (k == 33) bus.start = 1'b0;
        end
        n_total++; if (n_done !== 1) $display("FAIL hs_done_count: got %0d want 1", n_done); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL hs_idle_after: got busy %b want 0", bus.busy); else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_q[$];
        int t_done[$];
        logic [2:0] f; logic [31:0] a, b, e;
        @(negedge clk);
        f = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
        bus.start = 1'b1; bus.funct3 = f; bus.op_a = a; bus.op_b = b; bus.rd_in = 17;
        exp_q.push_back(model(f, a, b));
        for (int t = 0; t < 200 && t_done.size() < 3; t++) begin
            @(negedge clk);
            if (bus.done) begin
                e = exp_q.pop_front();
                n_total++; if (bus.result !== e) $display("FAIL b2b%0d_result: got %h want %h", t_done.size(), bus.result, e); else n_pass++;
                t_done.push_back(t);
                if (t_done.size() < 3) begin
                    f = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
                    bus.funct3 = f; bus.op_a = a; bus.op_b = b;
                    exp_q.push_back(model(f, a, b));
                end else bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        n_total++;
        if (t_done.size() !== 3) $display("FAIL b2b_count: got %0d dones want 3", t_done.size());
        else if (t_done[0] != 32 || t_done[1] - t_done[0] != 34 || t_done[2] - t_done[1] != 34)
            $display("FAIL b2b_spacing: got %0d,%0d,%0d want 32,66,100", t_done[0], t_done[1], t_done[2]);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        int n_done = 0;
        int lat; logic bok; logic [31:0] res; logic [4:0] rdo; logic weo;
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = F3_DIV; bus.op_a = 1000; bus.op_b = 7; bus.rd_in = 9;
        @(posedge clk);
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            if (k == 0) bus.start = 1'b0;
        end
        rst = 1'b1;
        #1;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", bus.busy); else n_pass++;
        n_total++; if (bus.done !== 1'b0) $display("FAIL rstmid_done: got %b want 0", bus.done); else n_pass++;
        n_total++; if (bus.we !== 1'b0) $display("FAIL rstmid_we: got %b want 0", bus.we); else n_pass++;
        n_total++; if (bus.result !== 32'h0) $display("FAIL rstmid_result: got %h want 0", bus.result); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done) n_done++;
        end
        n_total++; if (n_done !== 0) $display("FAIL rstmid_no_done: got %0d dones want 0", n_done); else n_pass++;
        do_op(F3_MUL, 3, 4, 3, lat, bok, res, rdo, weo);
        n_total++; if (res !== 32'd12) $display("FAIL rstmid_mul: got %h want c", res); else n_pass++;
        n_total++; if (lat !== 32) $display("FAIL rstmid_latency: got %0d want 32", lat); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_rd_zero();
        test_handshake();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
